// File: rtl/pim_acc_pkg.sv
// Shared types and default sizes for the PIM bit-serial shift-accumulate block.
package pim_acc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    localparam int ADC_P_DEF   = 8;
    localparam int IN_BITS_DEF = 8;

endpackage

// File: rtl/pim_shift_add.sv
// Combinational datapath: zero-extends one ADC result, shifts it by the bit-plane
// index and adds it to (or, for the sign plane, subtracts it from) the accumulator.
module pim_shift_add
    import pim_acc_pkg::*;
#(
    parameter int ADC_P   = ADC_P_DEF,
    parameter int IN_BITS = IN_BITS_DEF,
    parameter int ACC_W   = ADC_P + IN_BITS + 1,
    localparam int SW     = $clog2(IN_BITS)
) (
    input  logic signed [ACC_W-1:0] acc,
    input  logic        [ADC_P-1:0] in_data,
    input  logic        [SW-1:0]    shift,
    input  logic                    load,
    input  logic                    sub,
    output logic signed [ACC_W-1:0] sum
);

    logic signed [ACC_W-1:0] term;
    logic signed [ACC_W-1:0] base;

    always_comb begin
        term = $signed(ACC_W'(in_data) << shift);
        // The first plane starts a fresh sum regardless of what acc holds.
        base = load ? '0 : acc;
        sum  = sub ? (base - term) : (base + term);
    end

endmodule

// File: rtl/pim_shift_acc.sv
// Bit-serial shift-accumulate stage behind a PIM crossbar ADC; combines IN_BITS
// bit-plane partial sums into one signed dot product. Optional ReLU: PIM_ACC_RELU_EN.
module pim_shift_acc
    import pim_acc_pkg::*;
#(
    parameter int ADC_P   = ADC_P_DEF,
    parameter int IN_BITS = IN_BITS_DEF,
    parameter int ACC_W   = ADC_P + IN_BITS + 1,
    localparam int PW     = $clog2(IN_BITS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    abort,
    input  logic                    in_valid,
    input  logic        [ADC_P-1:0] in_data,
    output logic                    in_ready,
    output logic                    out_valid,
    output logic signed [ACC_W-1:0] out_data,
    input  logic                    out_ready,
    output logic        [PW-1:0]    plane_idx,
    output state_t                  state_dbg
);

    // Handshake: a beat moves on a port only in a cycle where valid and ready are
    // both high at the rising edge; out_valid/out_data hold until accepted.

    localparam logic [PW-1:0] LAST_PLANE = PW'(IN_BITS - 1);

    state_t                  state, state_next;
    logic signed [ACC_W-1:0] acc, acc_next, sum, result;
    logic        [PW-1:0]    plane_next;
    logic                    load, sub;

    assign load = (state == IDLE);
    assign sub  = (state == ACC) && (plane_idx == LAST_PLANE);

    pim_shift_add #(
        .ADC_P   (ADC_P),
        .IN_BITS (IN_BITS),
        .ACC_W   (ACC_W)
    ) u_shift_add (
        .acc     (acc),
        .in_data (in_data),
        .shift   (plane_idx),
        .load    (load),
        .sub     (sub),
        .sum     (sum)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            acc       <= '0;
            plane_idx <= '0;
        end else begin
            state     <= state_next;
            acc       <= acc_next;
            plane_idx <= plane_next;
        end
    end

    always_comb begin
        state_next = state;
        acc_next   = acc;
        plane_next = plane_idx;
        if (abort) begin
            state_next = IDLE;
            acc_next   = '0;
            plane_next = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        acc_next   = sum;
                        plane_next = PW'(1);
                        state_next = ACC;
                    end
                end
                ACC: begin
                    if (in_valid) begin
                        acc_next = sum;
                        if (plane_idx == LAST_PLANE) begin
                            state_next = OUT;
                        end else begin
                            plane_next = plane_idx + PW'(1);
                        end
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        state_next = IDLE;
                        acc_next   = '0;
                        plane_next = '0;
                    end
                end
                default: begin
                    state_next = IDLE;
                    acc_next   = '0;
                    plane_next = '0;
                end
            endcase
        end
    end

    always_comb begin
`ifdef PIM_ACC_RELU_EN
        result = acc[ACC_W-1] ? '0 : acc;
`else
        result = acc;
`endif
    end

    assign in_ready  = (state != OUT);
    assign out_valid = (state == OUT);
    // Partial sums stay internal; the output bus is zero outside OUT.
    assign out_data  = out_valid ? result : '0;
    assign state_dbg = state;

endmodule

// File: tb/tb_pim_shift_acc.sv
// Directed bench for pim_shift_acc at default widths; expected results are hand-computed.
module tb_pim_shift_acc;
    import pim_acc_pkg::*;

    localparam int ADC_P   = 8;
    localparam int IN_BITS = 8;
    localparam int ACC_W   = 17;
    localparam int PW      = 3;
`ifdef PIM_ACC_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    logic             clk, rst, abort, in_valid, in_ready, out_valid, out_ready;
    logic [ADC_P-1:0] in_data;
    logic [ACC_W-1:0] out_data;
    logic [PW-1:0]    plane_idx;
    state_t           state_dbg;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int fire_cnt = 0;
    logic [ACC_W-1:0] exp_q[$];
    logic [ACC_W-1:0] obs_q[$];
    int               obs_cyc[$];

    pim_shift_acc dut (
        .clk       (clk),
        .rst       (rst),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .plane_idx (plane_idx),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // output monitor feeding the scoreboard
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst && out_valid && out_ready && !abort) begin
            obs_q.push_back(out_data);
            obs_cyc.push_back(cyc);
            fire_cnt <= fire_cnt + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [ACC_W-1:0] relu_exp(input int v);
        return (RELU && v < 0) ? '0 : ACC_W'(v);
    endfunction

    // driver tasks
    task automatic send_word(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic send_op(input logic [63:0] planes);
        for (int i = 0; i < 8; i++) send_word(planes[8*i +: 8]);
    endtask

    task automatic wait_valid(output bit ok, output int waited);
        ok = 1'b0;
        waited = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) ok = 1'b1;
            else waited++;
        end
    endtask

    task automatic accept();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        total++; if (out_data !== '0) begin bad++; $display("FAIL reset_out_data: got %0d want 0", out_data); end
        total++; if (plane_idx !== '0) begin bad++; $display("FAIL reset_plane_idx: got %0d want 0", plane_idx); end
        total++; if (state_dbg !== IDLE) begin bad++; $display("FAIL reset_state: got %0d want %0d", state_dbg, IDLE); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_all_ones();
        bit ok; int w; int n0; logic [ACC_W-1:0] e, o;
        @(posedge clk); #1;
        n0 = fire_cnt;
        exp_q.push_back(relu_exp(-1));
        send_word(8'd1);
        total++; if (plane_idx !== 3'd1 || state_dbg !== ACC) begin bad++; $display("FAIL ones_first_plane: got idx=%0d st=%0d want idx=1 st=%0d", plane_idx, state_dbg, ACC); end
        for (int i = 1; i < 8; i++) send_word(8'd1);
        wait_valid(ok, w);
        total++; if (!ok || w != 0) begin bad++; $display("FAIL ones_latency: got ok=%0d wait=%0d want ok=1 wait=0", ok, w); end
        if (ok) accept();
        total++; if (fire_cnt != n0 + 1 || obs_q.size() == 0) begin bad++; $display("FAIL ones_count: got %0d want %0d", fire_cnt - n0, 1); end
        else begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); void'(obs_cyc.pop_front());
            total++; if (o !== e) begin bad++; $display("FAIL ones_data: got %0d want %0d", $signed(o), $signed(e)); end
        end
        total++; if (state_dbg !== IDLE || plane_idx !== '0 || in_ready !== 1'b1) begin bad++; $display("FAIL ones_return_idle: got st=%0d idx=%0d rdy=%b want st=0 idx=0 rdy=1", state_dbg, plane_idx, in_ready); end
        exp_q.delete();
    endtask

    task automatic test_extremes();
        bit ok; int w; logic [ACC_W-1:0] e;
        send_op(64'h00FF_FFFF_FFFF_FFFF);
        e = relu_exp(32385);
        wait_valid(ok, w);
        total++; if (!ok || out_data !== e) begin bad++; $display("FAIL pos_max: got %0d want %0d", $signed(out_data), $signed(e)); end
        if (ok) accept();
        send_op(64'hFF00_0000_0000_0000);
        e = relu_exp(-32640);
        wait_valid(ok, w);
        total++; if (!ok || out_data !== e) begin bad++; $display("FAIL sign_plane: got %0d want %0d", $signed(out_data), $signed(e)); end
        if (ok) accept();
        obs_q.delete(); obs_cyc.delete();
    endtask

    task automatic test_backpressure();
        bit ok; int w; int n0; logic [ACC_W-1:0] e;
        n0 = fire_cnt;
        e = relu_exp(5 - 128);
        send_op(64'h0100_0000_0000_0005);
        in_valid = 1'b1;
        in_data  = 8'd7;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid_%0d: got %b want 1", i, out_valid); end
            total++; if (out_data !== e) begin bad++; $display("FAIL bp_data_%0d: got %0d want %0d", i, $signed(out_data), $signed(e)); end
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready_%0d: got %b want 0", i, in_ready); end
        end
        @(posedge clk); #1;
        accept();
        in_valid = 1'b0;
        in_data  = '0;
        total++; if (state_dbg !== IDLE || plane_idx !== '0) begin bad++; $display("FAIL bp_no_capture: got st=%0d idx=%0d want st=0 idx=0", state_dbg, plane_idx); end
        total++; if (fire_cnt != n0 + 1 || obs_q.size() != 1) begin bad++; $display("FAIL bp_count: got %0d want 1", fire_cnt - n0); end
        else begin
            total++; if (obs_q[0] !== e) begin bad++; $display("FAIL bp_accepted: got %0d want %0d", $signed(obs_q[0]), $signed(e)); end
        end
        obs_q.delete(); obs_cyc.delete();
        wait_valid(ok, w);
        total++; if (ok) begin bad++; $display("FAIL bp_spurious: got out_valid=1 want 0"); end
    endtask

    task automatic test_back_to_back();
        logic [ACC_W-1:0] o, e;
        exp_q.push_back(relu_exp(-1));
        exp_q.push_back(relu_exp(2));
        out_ready = 1'b1;
        send_op(64'h0101_0101_0101_0101);
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_out_ready_block: got %b want 0", in_ready); end
        @(posedge clk); #1;
        send_op(64'h0000_0000_0000_0002);
        @(posedge clk); #1;
        out_ready = 1'b0;
        total++; if (obs_q.size() != 2) begin bad++; $display("FAIL b2b_count: got %0d want 2", obs_q.size()); end
        else begin
            total++; if (obs_cyc[1] - obs_cyc[0] != 9) begin bad++; $display("FAIL b2b_spacing: got %0d want 9", obs_cyc[1] - obs_cyc[0]); end
            while (exp_q.size() > 0) begin
                o = obs_q.pop_front(); e = exp_q.pop_front();
                total++; if (o !== e) begin bad++; $display("FAIL b2b_data: got %0d want %0d", $signed(o), $signed(e)); end
            end
        end
        exp_q.delete(); obs_q.delete(); obs_cyc.delete();
    endtask

    task automatic test_bubbles();
        bit ok; int w; logic [PW-1:0] p; logic [ACC_W-1:0] e;
        e = relu_exp(3 * 127 - 3 * 128);
        for (int i = 0; i < 8; i++) begin
            send_word(8'd3);
            p = plane_idx;
            @(posedge clk); #1;
            if (i == 3) begin
                total++; if (plane_idx !== p || p !== 3'd4) begin bad++; $display("FAIL bubble_hold: got %0d want 4", plane_idx); end
            end
        end
        wait_valid(ok, w);
        total++; if (!ok || out_data !== e) begin bad++; $display("FAIL bubble_data: got %0d want %0d", $signed(out_data), $signed(e)); end
        if (ok) accept();
        obs_q.delete(); obs_cyc.delete();
    endtask

    task automatic test_abort();
        bit ok; int w; int n0; logic [ACC_W-1:0] e;
        n0 = fire_cnt;
        e = relu_exp(-2);
        for (int i = 0; i < 4; i++) send_word(8'd1);
        abort = 1'b1; in_valid = 1'b1; in_data = 8'd9;
        @(posedge clk); #1;
        abort = 1'b0; in_valid = 1'b0; in_data = '0;
        total++; if (state_dbg !== IDLE || plane_idx !== '0) begin bad++; $display("FAIL abort_idle: got st=%0d idx=%0d want st=0 idx=0", state_dbg, plane_idx); end
        send_op(64'h0202_0202_0202_0202);
        wait_valid(ok, w);
        total++; if (!ok || out_data !== e) begin bad++; $display("FAIL abort_result: got %0d want %0d", $signed(out_data), $signed(e)); end
        if (ok) accept();
        total++; if (fire_cnt != n0 + 1) begin bad++; $display("FAIL abort_single_output: got %0d want 1", fire_cnt - n0); end
        send_op(64'h0101_0101_0101_0101);
        wait_valid(ok, w);
        n0 = fire_cnt;
        @(posedge clk); #1;
        abort = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; out_ready = 1'b0;
        total++; if (out_valid !== 1'b0 || state_dbg !== IDLE || fire_cnt != n0) begin bad++; $display("FAIL abort_in_out: got v=%b st=%0d fires=%0d want v=0 st=0 fires=0", out_valid, state_dbg, fire_cnt - n0); end
        obs_q.delete(); obs_cyc.delete();
    endtask

    task automatic test_reset_mid();
        bit ok; int w; int n0; logic [ACC_W-1:0] e;
        n0 = fire_cnt;
        e = relu_exp(-1);
        send_word(8'd1);
        @(posedge clk); #1;
        send_word(8'd1);
        send_word(8'd1);
        in_valid = 1'b1; in_data = 8'd1;
        #3 rst = 1'b0;
        @(negedge clk);
        total++; if (out_valid !== 1'b0 || out_data !== '0 || plane_idx !== '0 || state_dbg !== IDLE) begin bad++; $display("FAIL midrst_outputs: got v=%b d=%0d idx=%0d st=%0d want all 0", out_valid, out_data, plane_idx, state_dbg); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        send_op(64'h0101_0101_0101_0101);
        wait_valid(ok, w);
        total++; if (!ok || w != 0 || out_data !== e) begin bad++; $display("FAIL midrst_result: got %0d want %0d", $signed(out_data), $signed(e)); end
        if (ok) accept();
        total++; if (fire_cnt != n0 + 1) begin bad++; $display("FAIL midrst_count: got %0d want 1", fire_cnt - n0); end
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_extremes();
        test_backpressure();
        test_back_to_back();
        test_bubbles();
        test_abort();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
